// File: rtl/usrt_pkg.sv
// Shared USRT constants: data width, TX FIFO depth and frame layout.
// The serializer, deserializer and the TX/RX FIFOs all take their widths from here.
package usrt_pkg;

    localparam int unsigned USRT_DATA_W        = 8;
    localparam int unsigned USRT_TX_FIFO_DEPTH = 8;

    // Frame layout on the line: start, data, parity, stop.
    localparam int unsigned USRT_START_BITS  = 1;
    localparam int unsigned USRT_PARITY_BITS = 1;
    localparam int unsigned USRT_STOP_BITS   = 1;
    localparam int unsigned USRT_FRAME_BITS  =
        USRT_START_BITS + USRT_DATA_W + USRT_PARITY_BITS + USRT_STOP_BITS;

endpackage

// File: rtl/usrt_fifo_ptr.sv
// FIFO pointer/occupancy tracker: write and read pointers, count, and full/empty
// decoded from count. The caller qualifies push/pop; clr has priority over both.
module usrt_fifo_ptr
    import usrt_pkg::*;
#(
    parameter int unsigned DEPTH  = USRT_TX_FIFO_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [ADDR_W-1:0] rd_ptr_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [ADDR_W:0]   count_d, count_q;

    // Next-state for pointers and count; pointers wrap naturally at ADDR_W bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_d = count_q + 1'b1;
            else if (pop_i && !push_i) count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
    assign full_o   = (count_q == DepthCnt);
    assign empty_o  = (count_q == '0);

endmodule

// File: rtl/usrt_tx_fifo.sv
// USRT transmit byte buffer: FWFT FIFO between the APB write path and the serializer.
// Optional feature macro: USRT_TX_FIFO_AF_EN adds a registered almost_full output.
module usrt_tx_fifo
    import usrt_pkg::*;
#(
    parameter int unsigned DATA_W   = USRT_DATA_W,
    parameter int unsigned DEPTH    = USRT_TX_FIFO_DEPTH,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ovf
`ifdef USRT_TX_FIFO_AF_EN
    ,
    output logic              almost_full
`endif
);

    // Elaboration-time configuration sanity check.
    if (DEPTH < 2 || (1 << ADDR_W) != DEPTH || AF_LEVEL > DEPTH) begin : g_bad_cfg
        $error("usrt_tx_fifo: DEPTH must be a power of two >= 2 and AF_LEVEL <= DEPTH");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              push, pop;
    logic              ovf_d, ovf_q;

    // A pop while full frees the slot the push lands in, so the push is accepted.
    assign pop  = tx_ready & ~empty;
    assign push = wr_en & (~full | pop) & ~clr;

    usrt_fifo_ptr #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ptr (
        .clk_i   (pClk),
        .rst_ni  (pReset),
        .clr_i   (clr),
        .push_i  (push),
        .pop_i   (pop),
        .wr_ptr_o(wr_ptr),
        .rd_ptr_o(rd_ptr),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Storage write; the array is deliberately not reset.
    always_ff @(posedge pClk) begin
        if (push) mem_q[wr_ptr] <= wr_data;
    end

    // Sticky overflow: set when a push is dropped, cleared only by clr or reset.
    always_comb begin
        ovf_d = ovf_q;
        if (clr)                       ovf_d = 1'b0;
        else if (wr_en && full && !pop) ovf_d = 1'b1;
    end

    // Overflow flag register.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

    assign ovf      = ovf_q;
    assign tx_valid = ~empty;
    assign tx_data  = empty ? '0 : mem_q[rd_ptr];

`ifdef USRT_TX_FIFO_AF_EN
    localparam logic [ADDR_W:0] AfCnt = (ADDR_W + 1)'(AF_LEVEL);

    logic [ADDR_W:0] count_nxt;
    logic            af_d, af_q;

    // Mirror of the next occupancy so almost_full moves on the same edge as count.
    always_comb begin
        count_nxt = count;
        if (clr)                count_nxt = '0;
        else if (push && !pop)  count_nxt = count + 1'b1;
        else if (pop && !push)  count_nxt = count - 1'b1;
        af_d = (count_nxt >= AfCnt);
    end

    // Almost-full register.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) af_q <= 1'b0;
        else         af_q <= af_d;
    end

    assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_usrt_tx_fifo.sv
// Self-checking bench for usrt_tx_fifo: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_usrt_tx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;

    logic       pClk = 1'b0;
    logic       pReset = 1'b1;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_ready = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       ovf;
`ifdef USRT_TX_FIFO_AF_EN
    logic       almost_full;
`endif

    usrt_tx_fifo dut (
        .pClk       (pClk),
        .pReset     (pReset),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .ovf        (ovf)
`ifdef USRT_TX_FIFO_AF_EN
        ,
        .almost_full(almost_full)
`endif
    );

    always #5 pClk = ~pClk;

    // Reference model: queue of stored bytes, sticky overflow, registered almost-full.
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_af;
    logic [7:0] popped[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_af  = 0;
    endtask

    task automatic check_outputs(input string tag);
        int unsigned n = mq.size();
        check({tag, ".count"},    32'(count),    32'(n));
        check({tag, ".empty"},    32'(empty),    32'(n == 0));
        check({tag, ".full"},     32'(full),     32'(n == DEPTH));
        check({tag, ".tx_valid"}, 32'(tx_valid), 32'(n != 0));
        check({tag, ".tx_data"},  32'(tx_data),  (n != 0) ? 32'(mq[0]) : 32'h0);
        check({tag, ".ovf"},      32'(ovf),      32'(m_ovf));
`ifdef USRT_TX_FIFO_AF_EN
        check({tag, ".almost_full"}, 32'(almost_full), 32'(m_af));
`endif
    endtask

    // Apply one cycle of inputs, check current outputs, then advance model with the edge.
    task automatic step(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        bit do_pop;
        bit do_push;
        wr_en    = w;
        wr_data  = d;
        tx_ready = r;
        clr      = c;
        @(negedge pClk);
        check_outputs(tag);
        @(posedge pClk);
        if (c) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            do_pop  = r && (mq.size() != 0);
            do_push = w && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) popped.push_back(mq.pop_front());
            if (do_push) mq.push_back(d);
            if (w && !do_push) m_ovf = 1;
        end
        m_af = (mq.size() >= AF);
        #1;
    endtask

    initial begin
        model_reset();
        #1 pReset = 1'b0;
        #2;
        check_outputs("por");
        #10 pReset = 1'b1;
        @(posedge pClk);
        #1;

        // Fill and drain in order.
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
        check("fill.full_now", 32'(full), 32'd1);
        popped.delete();
        for (int i = 0; i < 9; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) check("drain.order", 32'(popped[i]), 32'((i + 1) * 8'h11));

        // Overflow then clr.
        for (int i = 0; i < 8; i++) step("ovf.fill", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        step("ovf.push", 1'b1, 8'hAA, 1'b0, 1'b0);
        step("ovf.hold", 1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf.set", 32'(ovf), 32'd1);
        step("ovf.clr", 1'b1, 8'h77, 1'b1, 1'b1);
        step("ovf.after", 1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf.cleared", 32'(ovf), 32'd0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) step("fpp.fill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step("fpp.pushpop", 1'b1, 8'h5C, 1'b1, 1'b0);
        popped.delete();
        for (int i = 0; i < 9; i++) step("fpp.drain", 1'b0, 8'h00, 1'b1, 1'b0);
        check("fpp.eighth", 32'(popped[7]), 32'h5C);

        // Empty with simultaneous push and ready.
        step("epp.pushpop", 1'b1, 8'h3E, 1'b1, 1'b0);
        step("epp.after", 1'b0, 8'h00, 1'b0, 1'b0);
        check("epp.data", 32'(tx_data), 32'h3E);

        // Reset mid-run with three bytes stored; takes effect without a clock edge.
        step("rst.push", 1'b1, 8'h21, 1'b0, 1'b0);
        step("rst.push", 1'b1, 8'h22, 1'b0, 1'b0);
        wr_en = 1'b0;
        #2 pReset = 1'b0;
        #1;
        model_reset();
        check_outputs("rst.async");
        #1 pReset = 1'b1;
        @(posedge pClk);
        #1;

        // Interleaved traffic across pointer wrap and the almost-full threshold.
        for (int i = 0; i < 20; i++)
            step("wrap", 1'b1, 8'($urandom), (i % 3) != 0, 1'b0);
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
        step("final", 1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
